unidade_controle_param: RTL



---
 rtl/unidade_controle_param.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/unidade_controle_param.sv
// Moore control unit for the sequence-repeat game: display phase, play timer, lives.
// Optional macro JOGADA_TIMEOUT_EN enables the espera_jogada timeout and final_timeout.
//
// state                | meaning
// inicial          00  | idle after reset
// preparacao       01  | clear datapath, load lives
// inicia_sequencia 02  | rewind address before display
// mostra_dado      03  | LEDs show current memory word
// intervalo_mostra 04  | blank gap between shown items
// proximo_mostra   05  | advance display address
// zera_endereco    06  | rewind address before play
// espera_jogada    07  | wait for a button press
// registra_jogada  08  | latch pressed buttons
// compara_jogada   09  | evaluate the press
// proxima_jogada   0A  | advance play address
// foi_ultima_seq   0B  | round finished, check last round
// proxima_sequencia0C  | extend round limit
// perde_vida       0D  | lose a life, replay round
// final_timeout    1D  | game over by timeout
// final_acertou    1E  | game won
// final_errou      1F  | game lost
module unidade_controle_param #(
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int SHOW_CYCLES    = 500,
   parameter int SHOW_GAP       = 250,
   parameter int MAX_LIVES      = 3,
   parameter int LIVES_W        = $clog2(MAX_LIVES + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               iniciar,
   input  logic               jogada,
   input  logic               botoesIgualMemoria,
   input  logic               fimL,
   input  logic               enderecoIgualLimite,
   input  logic               enderecoMenorLimite,
   output logic               zeraE,
   output logic               contaE,
   output logic               zeraL,
   output logic               contaL,
   output logic               zeraR,
   output logic               registraR,
   output logic               ativa_leds,
   output logic               acertou,
   output logic               errou,
   output logic               timeout_out,
   output logic               pronto,
   output logic [LIVES_W-1:0] vidas,
   output logic [4:0]         db_estado
);

   localparam int MAX_A   = (SHOW_CYCLES > SHOW_GAP) ? SHOW_CYCLES : SHOW_GAP;
   localparam int MAX_T   = (TIMEOUT_CYCLES > MAX_A) ? TIMEOUT_CYCLES : MAX_A;
   localparam int TIMER_W = (MAX_T < 2) ? 1 : $clog2(MAX_T);

   localparam logic [TIMER_W-1:0] SHOW_LAST = TIMER_W'(SHOW_CYCLES - 1);
   localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(SHOW_GAP - 1);
`ifdef JOGADA_TIMEOUT_EN
   localparam logic [TIMER_W-1:0] TO_LAST   = TIMER_W'(TIMEOUT_CYCLES - 1);
`endif

   typedef enum logic [4:0] {
      INICIAL          = 5'h00,
      PREPARACAO       = 5'h01,
      INICIA_SEQUENCIA = 5'h02,
      MOSTRA_DADO      = 5'h03,
      INTERVALO_MOSTRA = 5'h04,
      PROXIMO_MOSTRA   = 5'h05,
      ZERA_ENDERECO    = 5'h06,
      ESPERA_JOGADA    = 5'h07,
      REGISTRA_JOGADA  = 5'h08,
      COMPARA_JOGADA   = 5'h09,
      PROXIMA_JOGADA   = 5'h0A,
      FOI_ULTIMA_SEQ   = 5'h0B,
      PROXIMA_SEQ      = 5'h0C,
      PERDE_VIDA       = 5'h0D,
      FINAL_TIMEOUT    = 5'h1D,
      FINAL_ACERTOU    = 5'h1E,
      FINAL_ERROU      = 5'h1F
   } state_t;

   state_t             state, state_next;
   logic [TIMER_W-1:0] timer;
   logic               count_en;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= INICIAL;
      else        state <= state_next;
   end

   always_comb begin
      count_en = (state == MOSTRA_DADO) || (state == INTERVALO_MOSTRA);
`ifdef JOGADA_TIMEOUT_EN
      count_en = count_en || (state == ESPERA_JOGADA);
`endif
   end

   // Timer restarts from zero on every state change so each phase times itself.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                              timer <= '0;
      else if (state_next != state || !count_en) timer <= '0;
      else                                     timer <= timer + TIMER_W'(1);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         vidas <= LIVES_W'(MAX_LIVES);
      else if (state == PREPARACAO)
         vidas <= LIVES_W'(MAX_LIVES);
      else if (state_next == FINAL_ERROU && state != FINAL_ERROU)
         vidas <= '0;
      else if (state == PERDE_VIDA && vidas != '0)
         vidas <= vidas - LIVES_W'(1);
   end

   always_comb begin
      state_next  = state;
      zeraE       = 1'b0;
      contaE      = 1'b0;
      zeraL       = 1'b0;
      contaL      = 1'b0;
      zeraR       = 1'b0;
      registraR   = 1'b0;
      ativa_leds  = 1'b0;
      acertou     = 1'b0;
      errou       = 1'b0;
      timeout_out = 1'b0;
      pronto      = 1'b0;
      db_estado   = state;
      case (state)
         INICIAL: begin
            zeraL = 1'b1;
            zeraR = 1'b1;
            if (iniciar) state_next = PREPARACAO;
         end
         PREPARACAO: begin
            zeraL      = 1'b1;
            zeraR      = 1'b1;
            zeraE      = 1'b1;
            state_next = INICIA_SEQUENCIA;
         end
         INICIA_SEQUENCIA: begin
            zeraE      = 1'b1;
            state_next = MOSTRA_DADO;
         end
         MOSTRA_DADO: begin
            ativa_leds = 1'b1;
            if (timer == SHOW_LAST) state_next = INTERVALO_MOSTRA;
         end
         INTERVALO_MOSTRA: begin
            if (timer == GAP_LAST)
               state_next = enderecoIgualLimite ? ZERA_ENDERECO : PROXIMO_MOSTRA;
         end
         PROXIMO_MOSTRA: begin
            contaE     = 1'b1;
            state_next = MOSTRA_DADO;
         end
         ZERA_ENDERECO: begin
            zeraE      = 1'b1;
            state_next = ESPERA_JOGADA;
         end
         ESPERA_JOGADA: begin
            if (jogada) state_next = REGISTRA_JOGADA;
`ifdef JOGADA_TIMEOUT_EN
            else if (timer == TO_LAST) state_next = FINAL_TIMEOUT;
`endif
         end
         REGISTRA_JOGADA: begin
            registraR  = 1'b1;
            state_next = COMPARA_JOGADA;
         end
         COMPARA_JOGADA: begin
            if (botoesIgualMemoria)
               state_next = enderecoMenorLimite ? PROXIMA_JOGADA : FOI_ULTIMA_SEQ;
            else if (vidas > LIVES_W'(1))
               state_next = PERDE_VIDA;
            else
               state_next = FINAL_ERROU;
         end
         PROXIMA_JOGADA: begin
            contaE     = 1'b1;
            state_next = ESPERA_JOGADA;
         end
         FOI_ULTIMA_SEQ: state_next = fimL ? FINAL_ACERTOU : PROXIMA_SEQ;
         PROXIMA_SEQ: begin
            contaL     = 1'b1;
            state_next = INICIA_SEQUENCIA;
         end
         PERDE_VIDA: state_next = INICIA_SEQUENCIA;
         FINAL_TIMEOUT: begin
            pronto      = 1'b1;
            timeout_out = 1'b1;
            if (iniciar) state_next = PREPARACAO;
         end
         FINAL_ACERTOU: begin
            pronto  = 1'b1;
            acertou = 1'b1;
            if (iniciar) state_next = PREPARACAO;
         end
         FINAL_ERROU: begin
            pronto = 1'b1;
            errou  = 1'b1;
            if (iniciar) state_next = PREPARACAO;
         end
         default: begin
            state_next = INICIAL;
            db_estado  = 5'h10;
         end
      endcase
   end

endmodule
